// File: rtl/reg_file_mp_pkg.sv
// rf_pkg: shared register-file defaults and per-register reset constants
package rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int RST_IDX_A = 1;
  localparam int RST_VAL_A = 1;
  localparam int RST_IDX_B = 29;
  localparam int RST_VAL_B = 252;
  function automatic logic [63:0] RF_RST_VAL(input int i);
    return i == RST_IDX_A ? 64'(RST_VAL_A) : i == RST_IDX_B ? 64'(RST_VAL_B) : 64'd0;
  endfunction
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write, issue and status bundle of the register file
interface reg_file_mp_if
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2
);
  localparam int AW = $clog2(NREGS);
  logic [NRD-1:0][AW-1:0] rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_ready;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic iss_en;
  logic [AW-1:0] iss_addr;
  logic [NREGS-1:0] pend;
  logic [NREGS*XLEN-1:0] regs_flat;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input rd_data, rd_ready, pend, regs_flat
  );
  modport slave (
    input rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_ready, pend, regs_flat
  );
endinterface

// File: rtl/reg_file_mp_sb.sv
// rf_scoreboard: pending-destination vector, issue wins over a same-edge write clear
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS)
) (
  input logic clk,
  input logic reset,
  input logic wr_en,
  input logic [AW-1:0] wr_addr,
  input logic iss_en,
  input logic [AW-1:0] iss_addr,
  output logic [NREGS-1:0] pend,
  output logic [NREGS-1:0] pend_nxt
);
  logic [NREGS-1:0] set_v, clr_v;
  // next pending state: clear on write, then set on issue, register 0 never pending
  always_comb begin
    set_v = iss_en ? (NREGS'(1) << iss_addr) : '0;
    clr_v = wr_en ? (NREGS'(1) << wr_addr) : '0;
    pend_nxt = (set_v | (pend & ~clr_v)) & ~NREGS'(1);
  end
  // pending register, reset drops all in-flight producers
  always_ff @(posedge clk or posedge reset)
    pend <= reset ? '0 : pend_nxt;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with registered reads, optional write bypass and issue scoreboard
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic reset,
  reg_file_mp_if.slave bus
);
  typedef logic [NREGS-1:0][XLEN-1:0] img_t;
  function automatic img_t rst_image();
    img_t img;
    for (int i = 0; i < NREGS; i++) img[i] = XLEN'(RF_RST_VAL(i));
    return img;
  endfunction
  localparam img_t RST_IMG = rst_image();
  img_t regs;
  logic [NREGS-1:0] pend_nxt;
  logic we;
  assign we = bus.wr_en && bus.wr_addr != '0;
  // storage: reset image on reset, register 0 is never written so it stays 0
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= RST_IMG;
    else if (we) regs[bus.wr_addr] <= bus.wr_data;
  // read ports: data and ready captured every edge, ready tracks post-issue/clear pending state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.rd_data <= '0;
      bus.rd_ready <= '1;
    end else
      for (int p = 0; p < NRD; p++) begin
        bus.rd_data[p] <= (BYPASS != 0 && we && bus.wr_addr == bus.rd_addr[p]) ? bus.wr_data : regs[bus.rd_addr[p]];
        bus.rd_ready[p] <= !pend_nxt[bus.rd_addr[p]];
      end
  // delayed snapshot of all registers
  always_ff @(posedge clk or posedge reset)
    bus.regs_flat <= reset ? RST_IMG : regs;
  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .reset(reset),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr),
    .iss_en(bus.iss_en),
    .iss_addr(bus.iss_addr),
    .pend(bus.pend),
    .pend_nxt(pend_nxt)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: model-checked bench for write-first, read-old and 4-port builds
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  logic [1:0][4:0] rd_addr;
  logic wr_en, iss_en;
  logic [4:0] wr_addr, iss_addr;
  logic [31:0] wr_data;
  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ia ();
  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ib ();
  reg_file_mp_if #(.XLEN(16), .NREGS(16), .NRD(4)) ic ();
  assign ia.rd_addr = rd_addr;
  assign ia.wr_en = wr_en;
  assign ia.wr_addr = wr_addr;
  assign ia.wr_data = wr_data;
  assign ia.iss_en = iss_en;
  assign ia.iss_addr = iss_addr;
  assign ib.rd_addr = rd_addr;
  assign ib.wr_en = wr_en;
  assign ib.wr_addr = wr_addr;
  assign ib.wr_data = wr_data;
  assign ib.iss_en = iss_en;
  assign ib.iss_addr = iss_addr;
  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (.clk(clk), .reset(reset), .bus(ia));
  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_b (.clk(clk), .reset(reset), .bus(ib));
  reg_file_mp #(.XLEN(16), .NREGS(16), .NRD(4), .BYPASS(1)) u_c (.clk(clk), .reset(reset), .bus(ic));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  logic [31:0] m_mem [32];
  logic [31:0] m_pend, m_np;
  logic [31:0] e_wf [2];
  logic [31:0] e_ro [2];
  logic [1:0] e_rdy;
  logic [31:0] e_flat [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = (i == 1) ? 32'd1 : (i == 29) ? 32'd252 : 32'd0;
        e_flat[i] = m_mem[i];
      end
      m_pend = '0;
      e_wf = '{default: '0};
      e_ro = '{default: '0};
      e_rdy = 2'b11;
    end else begin
      m_np = m_pend;
      if (wr_en && wr_addr != 0) m_np[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_np[iss_addr] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        e_ro[p] = m_mem[rd_addr[p]];
        e_wf[p] = (wr_en && wr_addr != 0 && wr_addr == rd_addr[p]) ? wr_data : m_mem[rd_addr[p]];
        e_rdy[p] = !m_np[rd_addr[p]];
      end
      for (int i = 0; i < 32; i++) e_flat[i] = m_mem[i];
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      m_pend = m_np;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        check("a_rd_data", ia.rd_data[p], e_wf[p]);
        check("b_rd_data", ib.rd_data[p], e_ro[p]);
      end
      check("a_rd_ready", ia.rd_ready, e_rdy);
      check("b_rd_ready", ib.rd_ready, e_rdy);
      check("a_pend", ia.pend, m_pend);
      check("b_pend", ib.pend, m_pend);
      for (int i = 0; i < 32; i++) begin
        check("a_regs_flat", ia.regs_flat[i*32 +: 32], e_flat[i]);
        check("b_regs_flat", ib.regs_flat[i*32 +: 32], e_flat[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    iss_en = 1'b0;
    iss_addr = '0;
    ic.rd_addr = '0;
    ic.wr_en = 1'b0;
    ic.wr_addr = '0;
    ic.wr_data = '0;
    ic.iss_en = 1'b0;
    ic.iss_addr = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_rd_data", ia.rd_data, 64'd0);
    check("rst_rd_ready", ia.rd_ready, 64'h3);
    check("rst_pend", ia.pend, 64'd0);
    check("rst_flat_r1", ia.regs_flat[63:32], 64'd1);
    check("rst_flat_r29", ia.regs_flat[959:928], 64'd252);
    check("rst_c_flat_r1", ic.regs_flat[31:16], 64'd1);
    check("rst_c_ready", ic.rd_ready, 64'hf);
    @(negedge clk) reset = 1'b0;
    rd_addr[0] = 5'd1;
    rd_addr[1] = 5'd29;
    tick();
    check("rd_r1", ia.rd_data[0], 64'd1);
    check("rd_r29", ia.rd_data[1], 64'd252);
    check("rd_ready_11", ia.rd_ready, 64'h3);
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    rd_addr[0] = 5'd5;
    tick();
    check("wf_bypass", ia.rd_data[0], 64'hDEADBEEF);
    check("ro_old", ib.rd_data[0], 64'd0);
    wr_en = 1'b0;
    tick();
    check("ro_new", ib.rd_data[0], 64'hDEADBEEF);
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'h1234;
    rd_addr[0] = 5'd0;
    tick();
    check("r0_rd_a", ia.rd_data[0], 64'd0);
    check("r0_rd_b", ib.rd_data[0], 64'd0);
    wr_en = 1'b0;
    tick();
    check("r0_flat", ia.regs_flat[31:0], 64'd0);
    check("r0_pend", ia.pend[0], 64'd0);
    iss_en = 1'b1;
    iss_addr = 5'd7;
    rd_addr[0] = 5'd7;
    tick();
    check("iss7_pend", ia.pend[7], 64'd1);
    check("iss7_ready", ia.rd_ready[0], 64'd0);
    iss_en = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h77;
    tick();
    check("wr7_pend", ia.pend[7], 64'd0);
    check("wr7_ready", ia.rd_ready[0], 64'd1);
    iss_en = 1'b1;
    wr_data = 32'h78;
    tick();
    check("isswr7_pend", ia.pend[7], 64'd1);
    check("isswr7_ready", ia.rd_ready[0], 64'd0);
    check("isswr7_data", ia.rd_data[0], 64'h78);
    for (int i = 0; i < 24; i++) begin
      wr_en = (i % 3) != 2;
      wr_addr = 5'((i * 5) % 32);
      wr_data = (32'h01010101 * i) ^ 32'hA5000000;
      iss_en = (i % 2) == 1;
      iss_addr = 5'((i * 3) % 32);
      rd_addr[0] = 5'((i * 5) % 32);
      rd_addr[1] = 5'((i * 7 + 1) % 32);
      tick();
    end
    wr_en = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hA5;
    iss_en = 1'b1;
    iss_addr = 5'd12;
    tick();
    wr_en = 1'b0;
    iss_en = 1'b0;
    rd_addr[0] = 5'd9;
    tick();
    check("r9_before_rst", ia.rd_data[0], 64'hA5);
    check("p12_before_rst", ia.pend[12], 64'd1);
    #3 reset = 1'b1;
    #1;
    check("async_flat_r9", ia.regs_flat[319:288], 64'd0);
    check("async_pend", ia.pend, 64'd0);
    check("async_rd_a", ia.rd_data, 64'd0);
    check("async_rd_b", ib.rd_data, 64'd0);
    wr_en = 1'b1;
    wr_addr = 5'd10;
    wr_data = 32'h55;
    iss_en = 1'b1;
    iss_addr = 5'd10;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    iss_en = 1'b0;
    rd_addr[0] = 5'd10;
    tick();
    check("rst_wr_dropped", ia.rd_data[0], 64'd0);
    check("rst_iss_dropped", ia.pend[10], 64'd0);
    ic.wr_en = 1'b1;
    ic.wr_addr = 4'd3;
    ic.wr_data = 16'hBEEF;
    tick();
    ic.wr_en = 1'b0;
    ic.rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
    tick();
    for (int p = 0; p < 4; p++) check("c_port_r3", ic.rd_data[p], 64'hBEEF);
    check("c_flat_r3", ic.regs_flat[63:48], 64'hBEEF);
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
